cpu_mc: RTL and testbench
=========================

# cpu_mc

Parametrised multicycle successor to the single-cycle 24-bit-instruction CPU. Fetches from an external instruction ROM, decodes the fixed 24-bit format, executes on an internal register file, and talks to data memory through a ready-qualified read/write handshake. Adds a PC/branch unit, load/store stalls, a HALT state and an optional multiplier. Sits between the instruction ROM and the data memory/IO bus at the top level.

## Interface
- DATA_W, 16, datapath and register width; power of two, 8..32
- IADDR_W, 8, instruction address width; PC wraps modulo 2^IADDR_W
- NREGS, 16, register count; fixed at 16 by the 4-bit register fields
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- instr  in  24  instruction word for `iaddr`; combinational ROM, valid same cycle
- iaddr  out  IADDR_W  program counter
- data_in  in  DATA_W  read data; sampled when `data_rd && dmem_rdy`
- dmem_rdy  in  1  memory completes the current read/write this cycle
- data_rd  out  1  read strobe
- data_wr  out  1  write strobe
- daddr  out  16  data address
- data_out  out  DATA_W  write data
- halted  out  1  high while in HALT

## Operation
- Fields: op=instr[23:20], dst=[19:16], ra=[11:8], rb=[3:0], imm8=[7:0], addr16=[15:0].
- r0 reads 0; writes to r0 discarded. Arithmetic mod 2^DATA_W, no flags.
- Opcodes: 0 NOP; 1 ADD dst=ra+rb; 2 SUB dst=ra-rb; 3 AND; 4 OR; 5 XOR; 6 LDI dst=zero-ext imm8; 7 LD dst=mem[addr16]; 8 ST mem[addr16]=dst; 9 JMP pc=imm8; A BRZ if dst==0 pc=imm8 else pc+1; B SHL dst=ra<<sh; C SHR dst=ra>>sh (logical); D MUL (see Configuration); E HALT; F reserved, executes as NOP.
- sh = low log2(DATA_W) bits of rb; imm8 jump targets truncated/zero-extended to IADDR_W.
- FSM states: FETCH, EXEC, MEM, HALT.
  - FETCH: latch instr into IR -> EXEC.
  - EXEC: ALU/LDI/shift write dst, pc+1 -> FETCH; JMP/BRZ load pc -> FETCH; LD/ST drive daddr, strobe, data_out -> MEM; HALT -> HALT.
  - MEM: hold daddr, data_out, strobe stable until dmem_rdy=1; on that edge LD writes data_in to dst, pc+1, strobe drops -> FETCH.
  - HALT: all strobes low, pc frozen; exit only by reset.
- data_rd and data_wr never high together; never high outside MEM.

## Timing
- Reset (async, rst=0): pc=0, all regs=0, IR=0, state=FETCH, iaddr=0, daddr=0, data_out=0, data_rd=0, data_wr=0, halted=0. Reset mid-MEM drops strobes immediately; transaction is abandoned.
- Latency: ALU/LDI/NOP/jump 2 cycles; LD/ST 2 + N cycles, N>=1 = cycles until dmem_rdy seen (dmem_rdy already high on MEM entry gives 3 cycles).
- dmem_rdy ignored outside MEM.
- Register write visible to the next instruction's EXEC (no hazard; one instruction in flight).
- pc=2^IADDR_W-1 with pc+1 wraps to 0.
- halted asserts the cycle after EXEC of HALT.

## Configuration
- CPU_MC_MULT_EN defined: opcode D = MUL, dst = low DATA_W bits of ra*rb, 2-cycle latency like ALU ops.
- Undefined: opcode D executes as NOP; no multiplier synthesised.

## Structure
- Package cpu_pkg: opcode enum, FSM state enum, instruction field bit positions, instruction width 24.
- Sub-module cpu_alu: combinational ADD/SUB/logic/shift/MUL on DATA_W, opcode-selected; FSM, PC, register file and memory handshake stay in cpu_mc.

## Test plan
- Reset: rst=0 mid-run -> iaddr=0, strobes 0, halted 0; release -> fetch from 0.
- LDI r1,5; LDI r2,3; SUB r3,r1,r2; ADD r0,r1,r1 -> r3=2, r0 reads 0; SUB r4,r2,r1 -> 0xFFFE (DATA_W=16).
- ST r3,0x0040 with dmem_rdy low 3 cycles -> data_wr held 4 MEM cycles, daddr=0x0040, data_out=2; LD r5,0x0040 returning 0x1234 -> r5=0x1234.
- BRZ r0 to 0x10 -> iaddr=0x10; BRZ r1 (nonzero) -> pc+1; JMP at pc=0xFF (IADDR_W=8) with pc+1 path -> wraps to 0.
- SHL r6,r1,r7 with r7=17 -> shift by 1 -> 10; MUL 5*3 -> 15 with CPU_MC_MULT_EN, r-dst unchanged without.
- HALT -> halted=1, iaddr frozen, no strobes for 20 cycles; rst exits.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu_mc multicycle CPU: opcodes, FSM states, instruction fields.
package cpu_pkg;

    localparam int unsigned INSTR_W   = 24;
    localparam int unsigned OP_W      = 4;
    localparam int unsigned REG_IDX_W = 4;
    localparam int unsigned DADDR_W   = 16;
    localparam int unsigned IMM_W     = 8;

    localparam int unsigned OP_MSB   = 23;
    localparam int unsigned OP_LSB   = 20;
    localparam int unsigned DST_MSB  = 19;
    localparam int unsigned DST_LSB  = 16;
    localparam int unsigned RA_MSB   = 11;
    localparam int unsigned RA_LSB   = 8;
    localparam int unsigned RB_MSB   = 3;
    localparam int unsigned RB_LSB   = 0;
    localparam int unsigned IMM_MSB  = 7;
    localparam int unsigned ADDR_MSB = 15;

    typedef enum logic [OP_W-1:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_LDI  = 4'h6,
        OP_LD   = 4'h7,
        OP_ST   = 4'h8,
        OP_JMP  = 4'h9,
        OP_BRZ  = 4'hA,
        OP_SHL  = 4'hB,
        OP_SHR  = 4'hC,
        OP_MUL  = 4'hD,
        OP_HALT = 4'hE,
        OP_RSVD = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_MEM   = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for cpu_mc: add/sub/logic/shift, and multiply when CPU_MC_MULT_EN is defined.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  opcode_e             op_i,
    input  logic [DATA_W-1:0]   a_i,
    input  logic [DATA_W-1:0]   b_i,
    output logic [DATA_W-1:0]   y_o
);

    localparam int unsigned SH_W = $clog2(DATA_W);

    logic [SH_W-1:0] sh;
    assign sh = b_i[SH_W-1:0];

    always_comb begin
        y_o = '0;
        case (op_i)
            OP_ADD: y_o = a_i + b_i;
            OP_SUB: y_o = a_i - b_i;
            OP_AND: y_o = a_i & b_i;
            OP_OR:  y_o = a_i | b_i;
            OP_XOR: y_o = a_i ^ b_i;
            OP_SHL: y_o = a_i << sh;
            OP_SHR: y_o = a_i >> sh;
`ifdef CPU_MC_MULT_EN
            OP_MUL: y_o = DATA_W'(a_i * b_i);
`endif
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/cpu_mc.sv
// Multicycle 24-bit-instruction CPU: FETCH/EXEC/MEM/HALT sequencer, PC, register file, data-memory handshake.
// Optional multiplier for opcode D is enabled by defining CPU_MC_MULT_EN.
module cpu_mc
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned IADDR_W = 8,
    parameter int unsigned NREGS   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [INSTR_W-1:0]   instr,
    output logic [IADDR_W-1:0]   iaddr,
    input  logic [DATA_W-1:0]    data_in,
    input  logic                 dmem_rdy,
    output logic                 data_rd,
    output logic                 data_wr,
    output logic [DADDR_W-1:0]   daddr,
    output logic [DATA_W-1:0]    data_out,
    output logic                 halted
);

    state_e               state_q, state_d;
    logic [IADDR_W-1:0]   pc_q, pc_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic                 rd_q, rd_d;
    logic                 wr_q, wr_d;
    logic [DADDR_W-1:0]   daddr_q, daddr_d;
    logic [DATA_W-1:0]    dout_q, dout_d;
    logic                 halted_q, halted_d;

    logic [DATA_W-1:0]    regs_q [NREGS];

    logic                 rf_we;
    logic [REG_IDX_W-1:0] rf_waddr;
    logic [DATA_W-1:0]    rf_wdata;

    opcode_e              op;
    logic [REG_IDX_W-1:0] dst, ra, rb;
    logic [IMM_W-1:0]     imm8;
    logic [DADDR_W-1:0]   addr16;
    logic [DATA_W-1:0]    dst_val, ra_val, rb_val, alu_y;
    logic [IADDR_W-1:0]   pc_inc, jmp_tgt;

    assign op      = opcode_e'(ir_q[OP_MSB:OP_LSB]);
    assign dst     = ir_q[DST_MSB:DST_LSB];
    assign ra      = ir_q[RA_MSB:RA_LSB];
    assign rb      = ir_q[RB_MSB:RB_LSB];
    assign imm8    = ir_q[IMM_MSB:0];
    assign addr16  = ir_q[ADDR_MSB:0];

    // r0 is hardwired to zero on every read port
    assign dst_val = (dst == '0) ? '0 : regs_q[dst];
    assign ra_val  = (ra  == '0) ? '0 : regs_q[ra];
    assign rb_val  = (rb  == '0) ? '0 : regs_q[rb];

    assign pc_inc  = pc_q + IADDR_W'(1);
    assign jmp_tgt = IADDR_W'(imm8);

    cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .op_i (op),
        .a_i  (ra_val),
        .b_i  (rb_val),
        .y_o  (alu_y)
    );

    // Next-state, PC, strobe and register-write decode
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        daddr_d  = daddr_q;
        dout_d   = dout_q;
        halted_d = halted_q;
        rf_we    = 1'b0;
        rf_waddr = dst;
        rf_wdata = alu_y;

        case (state_q)
            ST_FETCH: begin
                ir_d    = instr;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                pc_d    = pc_inc;
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
                        rf_we = 1'b1;
                    end
                    OP_MUL: begin
`ifdef CPU_MC_MULT_EN
                        rf_we = 1'b1;
`endif
                    end
                    OP_LDI: begin
                        rf_we    = 1'b1;
                        rf_wdata = DATA_W'(imm8);
                    end
                    OP_LD: begin
                        rd_d    = 1'b1;
                        daddr_d = addr16;
                        pc_d    = pc_q;
                        state_d = ST_MEM;
                    end
                    OP_ST: begin
                        wr_d    = 1'b1;
                        daddr_d = addr16;
                        dout_d  = dst_val;
                        pc_d    = pc_q;
                        state_d = ST_MEM;
                    end
                    OP_JMP: pc_d = jmp_tgt;
                    OP_BRZ: begin
                        if (dst_val == '0) begin
                            pc_d = jmp_tgt;
                        end
                    end
                    OP_HALT: begin
                        pc_d     = pc_q;
                        halted_d = 1'b1;
                        state_d  = ST_HALT;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                // Address, data and strobe stay registered until the memory completes
                if (dmem_rdy) begin
                    rf_we    = rd_q;
                    rf_wdata = data_in;
                    rd_d     = 1'b0;
                    wr_d     = 1'b0;
                    pc_d     = pc_inc;
                    state_d  = ST_FETCH;
                end
            end
            ST_HALT: ;
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_FETCH;
            pc_q     <= '0;
            ir_q     <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            daddr_q  <= '0;
            dout_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            daddr_q  <= daddr_d;
            dout_q   <= dout_d;
            halted_q <= halted_d;
        end
    end

    // Register file; writes to r0 are dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (rf_we && (rf_waddr != '0)) begin
            regs_q[rf_waddr] <= rf_wdata;
        end
    end

    assign iaddr    = pc_q;
    assign data_rd  = rd_q;
    assign data_wr  = wr_q;
    assign daddr    = daddr_q;
    assign data_out = dout_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_cpu_mc.sv
// Directed self-checking bench for cpu_mc: ROM model, latency-programmable data memory, per-feature tasks.
`timescale 1ns/1ps
module tb_cpu_mc;

    logic        clk;
    logic        rst;
    logic [23:0] instr;
    logic [7:0]  iaddr;
    logic [15:0] data_in;
    logic        dmem_rdy;
    logic        data_rd;
    logic        data_wr;
    logic [15:0] daddr;
    logic [15:0] data_out;
    logic        halted;

    int checks = 0;
    int errors = 0;

    logic [23:0] rom  [256];
    logic [15:0] dmem [256];

    int          mem_lat = 0;
    int          busy_cnt = 0;
    int          rd_cyc_last = 0;
    int          unstable = 0;
    int          both_high = 0;
    int          halt_strobe = 0;
    logic [15:0] first_addr;
    logic [15:0] first_dout;
    logic [15:0] wlog_addr [$];
    logic [15:0] wlog_data [$];
    int          wlog_cyc  [$];

    cpu_mc dut (
        .clk      (clk),
        .rst      (rst),
        .instr    (instr),
        .iaddr    (iaddr),
        .data_in  (data_in),
        .dmem_rdy (dmem_rdy),
        .data_rd  (data_rd),
        .data_wr  (data_wr),
        .daddr    (daddr),
        .data_out (data_out),
        .halted   (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign instr = rom[iaddr];

    // Data memory: holds dmem_rdy low for mem_lat MEM cycles, logs completed writes
    always @(negedge clk) begin
        if (!rst) begin
            busy_cnt = 0;
            dmem_rdy = 1'b0;
            data_in  = '0;
        end else if (data_rd || data_wr) begin
            if (busy_cnt == 0) begin
                first_addr = daddr;
                first_dout = data_out;
            end else if (daddr !== first_addr || (data_wr && data_out !== first_dout)) begin
                unstable++;
            end
            if (data_rd && data_wr) both_high++;
            if (halted) halt_strobe++;
            data_in = dmem[daddr[7:0]];
            if (busy_cnt >= mem_lat) begin
                dmem_rdy = 1'b1;
                if (data_wr) begin
                    dmem[daddr[7:0]] = data_out;
                    wlog_addr.push_back(daddr);
                    wlog_data.push_back(data_out);
                    wlog_cyc.push_back(busy_cnt + 1);
                end else begin
                    rd_cyc_last = busy_cnt + 1;
                end
            end else begin
                dmem_rdy = 1'b0;
            end
            busy_cnt++;
        end else begin
            busy_cnt = 0;
            dmem_rdy = 1'b0;
            data_in  = '0;
        end
    end

    function automatic logic [23:0] enc_r(input logic [3:0] op, input logic [3:0] d,
                                          input logic [3:0] a, input logic [3:0] b);
        return {op, d, 4'h0, a, 4'h0, b};
    endfunction

    function automatic logic [23:0] enc_i(input logic [3:0] op, input logic [3:0] d,
                                          input logic [7:0] imm);
        return {op, d, 8'h00, imm};
    endfunction

    function automatic logic [23:0] enc_m(input logic [3:0] op, input logic [3:0] d,
                                          input logic [15:0] adr);
        return {op, d, adr};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 24'h0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        wlog_addr.delete();
        wlog_data.delete();
        wlog_cyc.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_to_halt(input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_timeout: halted=%0b required 1", halted);
        end
    endtask

    task automatic test_reset();
        int n = 0;
        clear_rom();
        rom[1] = enc_m(4'h7, 4'd1, 16'h0050);
        rom[2] = enc_r(4'hE, 4'd0, 4'd0, 4'd0);
        mem_lat = 1000;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (iaddr !== 8'h00) begin errors++; $display("FAIL reset_iaddr: got %h required 00", iaddr); end
        checks++; if ({data_rd, data_wr} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b required 00", {data_rd, data_wr}); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b required 0", halted); end
        checks++; if ({daddr, data_out} !== 32'h0) begin errors++; $display("FAIL reset_daddr_dout: got %h required 0", {daddr, data_out}); end
        rst = 1'b1;
        while (!data_rd && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (data_rd !== 1'b1) begin errors++; $display("FAIL reset_ld_start: data_rd=%b required 1", data_rd); end
        #2 rst = 1'b0;
        #1;
        checks++; if ({data_rd, data_wr} !== 2'b00) begin errors++; $display("FAIL reset_mid_mem_strobes: got %b required 00", {data_rd, data_wr}); end
        checks++; if (iaddr !== 8'h00) begin errors++; $display("FAIL reset_mid_mem_iaddr: got %h required 00", iaddr); end
        @(negedge clk);
        mem_lat = 0;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (iaddr !== 8'h00) begin errors++; $display("FAIL reset_fetch0: got %h required 00", iaddr); end
        @(negedge clk);
        checks++; if (iaddr !== 8'h01) begin errors++; $display("FAIL reset_nop_latency: got %h required 01", iaddr); end
        run_to_halt(50);
        checks++; if (rd_cyc_last !== 1) begin errors++; $display("FAIL ld_rdy_on_entry: mem cycles %0d required 1", rd_cyc_last); end
    endtask

    task automatic test_alu();
        logic [15:0] exp_a [6] = '{16'h40, 16'h41, 16'h42, 16'h43, 16'h44, 16'h45};
        logic [15:0] exp_d [6] = '{16'h0002, 16'h0000, 16'hFFFE, 16'h0006, 16'h0001, 16'h0007};
        clear_rom();
        rom[0]  = enc_i(4'h6, 4'd1, 8'd5);
        rom[1]  = enc_i(4'h6, 4'd2, 8'd3);
        rom[2]  = enc_r(4'h2, 4'd3, 4'd1, 4'd2);
        rom[3]  = enc_r(4'h1, 4'd0, 4'd1, 4'd1);
        rom[4]  = enc_r(4'h2, 4'd4, 4'd2, 4'd1);
        rom[5]  = enc_m(4'h8, 4'd3, 16'h0040);
        rom[6]  = enc_m(4'h8, 4'd0, 16'h0041);
        rom[7]  = enc_m(4'h8, 4'd4, 16'h0042);
        rom[8]  = enc_r(4'h5, 4'd5, 4'd1, 4'd2);
        rom[9]  = enc_r(4'h3, 4'd6, 4'd1, 4'd2);
        rom[10] = enc_r(4'h4, 4'd7, 4'd1, 4'd2);
        rom[11] = enc_m(4'h8, 4'd5, 16'h0043);
        rom[12] = enc_m(4'h8, 4'd6, 16'h0044);
        rom[13] = enc_m(4'h8, 4'd7, 16'h0045);
        rom[14] = enc_r(4'hE, 4'd0, 4'd0, 4'd0);
        mem_lat = 0;
        do_reset();
        run_to_halt(500);
        checks++; if (wlog_addr.size() != 6) begin errors++; $display("FAIL alu_store_count: got %0d required 6", wlog_addr.size()); end
        for (int i = 0; i < 6 && i < wlog_addr.size(); i++) begin
            checks++; if (wlog_addr[i] !== exp_a[i]) begin errors++; $display("FAIL alu_addr[%0d]: got %h required %h", i, wlog_addr[i], exp_a[i]); end
            checks++; if (wlog_data[i] !== exp_d[i]) begin errors++; $display("FAIL alu_data[%0d]: got %h required %h", i, wlog_data[i], exp_d[i]); end
        end
    endtask

    task automatic test_mem();
        int n = 0;
        clear_rom();
        dmem[8'h50] = 16'h1234;
        rom[0] = enc_i(4'h6, 4'd3, 8'd2);
        rom[1] = enc_m(4'h8, 4'd3, 16'h0040);
        rom[2] = enc_m(4'h7, 4'd5, 16'h0050);
        rom[3] = enc_m(4'h8, 4'd5, 16'h0051);
        rom[4] = enc_r(4'hE, 4'd0, 4'd0, 4'd0);
        unstable = 0;
        rd_cyc_last = 0;
        mem_lat = 3;
        do_reset();
        while (wlog_addr.size() == 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        mem_lat = 0;
        run_to_halt(100);
        checks++; if (wlog_addr.size() != 2) begin errors++; $display("FAIL mem_store_count: got %0d required 2", wlog_addr.size()); end
        if (wlog_addr.size() == 2) begin
            checks++; if (wlog_addr[0] !== 16'h0040) begin errors++; $display("FAIL st_daddr: got %h required 0040", wlog_addr[0]); end
            checks++; if (wlog_data[0] !== 16'h0002) begin errors++; $display("FAIL st_data_out: got %h required 0002", wlog_data[0]); end
            checks++; if (wlog_cyc[0] !== 4) begin errors++; $display("FAIL st_wr_cycles: got %0d required 4", wlog_cyc[0]); end
            checks++; if (wlog_data[1] !== 16'h1234) begin errors++; $display("FAIL ld_value: got %h required 1234", wlog_data[1]); end
        end
        checks++; if (rd_cyc_last !== 1) begin errors++; $display("FAIL ld_cycles: got %0d required 1", rd_cyc_last); end
        checks++; if (unstable !== 0) begin errors++; $display("FAIL mem_hold_stable: %0d changes required 0", unstable); end
    endtask

    task automatic test_branch();
        clear_rom();
        rom[8'h00] = enc_i(4'hA, 4'd9, 8'h10);
        rom[8'h01] = enc_m(4'h8, 4'd9, 16'h0062);
        rom[8'h02] = enc_r(4'hE, 4'd0, 4'd0, 4'd0);
        rom[8'h10] = enc_i(4'h6, 4'd1, 8'd1);
        rom[8'h11] = enc_i(4'hA, 4'd0, 8'h30);
        rom[8'h12] = enc_m(4'h8, 4'd1, 16'h0060);
        rom[8'h30] = enc_i(4'hA, 4'd1, 8'h40);
        rom[8'h31] = enc_m(4'h8, 4'd1, 16'h0061);
        rom[8'h32] = enc_i(4'h6, 4'd9, 8'd7);
        rom[8'h33] = enc_i(4'h9, 4'd0, 8'hFF);
        rom[8'hFF] = 24'h000000;
        mem_lat = 0;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        checks++; if (iaddr !== 8'h10) begin errors++; $display("FAIL brz_taken_iaddr: got %h required 10", iaddr); end
        run_to_halt(200);
        checks++; if (iaddr !== 8'h02) begin errors++; $display("FAIL wrap_halt_iaddr: got %h required 02", iaddr); end
        checks++; if (wlog_addr.size() != 2) begin errors++; $display("FAIL branch_store_count: got %0d required 2", wlog_addr.size()); end
        if (wlog_addr.size() == 2) begin
            checks++; if ({wlog_addr[0], wlog_data[0]} !== 32'h0061_0001) begin errors++; $display("FAIL brz_not_taken: got %h/%h required 0061/0001", wlog_addr[0], wlog_data[0]); end
            checks++; if ({wlog_addr[1], wlog_data[1]} !== 32'h0062_0007) begin errors++; $display("FAIL pc_wrap: got %h/%h required 0062/0007", wlog_addr[1], wlog_data[1]); end
        end
    endtask

    task automatic test_shift_mul();
        logic [15:0] exp_mul;
`ifdef CPU_MC_MULT_EN
        exp_mul = 16'd15;
`else
        exp_mul = 16'h0077;
`endif
        clear_rom();
        rom[0]  = enc_i(4'h6, 4'd1, 8'd5);
        rom[1]  = enc_i(4'h6, 4'd7, 8'd17);
        rom[2]  = enc_r(4'hB, 4'd6, 4'd1, 4'd7);
        rom[3]  = enc_r(4'hC, 4'd8, 4'd6, 4'd7);
        rom[4]  = enc_i(4'h6, 4'd2, 8'd3);
        rom[5]  = enc_i(4'h6, 4'd10, 8'h77);
        rom[6]  = enc_r(4'hD, 4'd10, 4'd1, 4'd2);
        rom[7]  = enc_m(4'h8, 4'd6, 16'h0070);
        rom[8]  = enc_m(4'h8, 4'd8, 16'h0071);
        rom[9]  = enc_m(4'h8, 4'd10, 16'h0072);
        rom[10] = enc_r(4'hE, 4'd0, 4'd0, 4'd0);
        mem_lat = 0;
        do_reset();
        run_to_halt(300);
        checks++; if (wlog_addr.size() != 3) begin errors++; $display("FAIL shmul_store_count: got %0d required 3", wlog_addr.size()); end
        if (wlog_addr.size() == 3) begin
            checks++; if (wlog_data[0] !== 16'd10) begin errors++; $display("FAIL shl_by_17: got %h required 000a", wlog_data[0]); end
            checks++; if (wlog_data[1] !== 16'd5) begin errors++; $display("FAIL shr_by_17: got %h required 0005", wlog_data[1]); end
            checks++; if (wlog_data[2] !== exp_mul) begin errors++; $display("FAIL mul: got %h required %h", wlog_data[2], exp_mul); end
        end
    endtask

    task automatic test_halt();
        int bad = 0;
        clear_rom();
        rom[0] = enc_r(4'hF, 4'd1, 4'd2, 4'd3);
        rom[1] = enc_r(4'hE, 4'd0, 4'd0, 4'd0);
        mem_lat = 0;
        halt_strobe = 0;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        checks++; if (iaddr !== 8'h01) begin errors++; $display("FAIL rsvd_as_nop: iaddr %h required 01", iaddr); end
        @(negedge clk);
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_in_exec: halted %b required 0", halted); end
        @(negedge clk);
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_assert: halted %b required 1", halted); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (iaddr !== 8'h01 || data_rd !== 1'b0 || data_wr !== 1'b0 || halted !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL halt_frozen: %0d bad cycles required 0", bad); end
        rst = 1'b0;
        #1;
        checks++; if ({halted, iaddr} !== 9'h000) begin errors++; $display("FAIL halt_reset_exit: halted/iaddr %b/%h required 0/00", halted, iaddr); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 256; i++) dmem[i] = '0;
        test_reset();
        test_alu();
        test_mem();
        test_branch();
        test_shift_mul();
        test_halt();
        checks++; if (both_high !== 0) begin errors++; $display("FAIL rd_wr_exclusive: %0d overlaps required 0", both_high); end
        checks++; if (halt_strobe !== 0) begin errors++; $display("FAIL strobe_in_halt: %0d required 0", halt_strobe); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
